pc_sequencer: RTL and testbench

Parametrised program-counter unit replacing the single-register PC in the fetch stage. It holds the PC with stall support and selects the next PC by fixed priority from redirect, call, return and sequential sources. It also contains a circular return-address stack (RAS) that predicts return targets. It feeds instruction-memory addressing and passes PC+INCR to the decode stage.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer_ras_stack.sv | 75 +++++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC source
// encoding and default address constants.
package pc_pkg;

  // Which source feeds the PC register on the next edge.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_REDIRECT,
    SRC_CALL,
    SRC_RETURN,
    SRC_EXC,
    SRC_ERET
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [31:0] DEF_INCR         = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side control/PC bus of the program-counter sequencer.
// Optional macro: PC_EXCEPTION_EN adds Exception, ERet and EPC.
interface pc_sequencer_if #(
  parameter int N = 32
);
  logic         PCWrite;
  logic         Redirect;
  logic         Call;
  logic         Return;
  logic [N-1:0] RedirectPC;
  logic [N-1:0] PCValue;
  logic [N-1:0] PCPlus;
`ifdef PC_EXCEPTION_EN
  logic         Exception;
  logic         ERet;
  logic [N-1:0] EPC;

  modport master (output PCWrite, Redirect, Call, Return, RedirectPC, Exception, ERet,
                  input  PCValue, PCPlus, EPC);
  modport slave  (input  PCWrite, Redirect, Call, Return, RedirectPC, Exception, ERet,
                  output PCValue, PCPlus, EPC);
`else
  modport master (output PCWrite, Redirect, Call, Return, RedirectPC,
                  input  PCValue, PCPlus);
  modport slave  (input  PCWrite, Redirect, Call, Return, RedirectPC,
                  output PCValue, PCPlus);
`endif
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; push+pop together replaces the top (or pushes when empty).
module ras_stack #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_en,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [N-1:0]                 i_din,
  output logic [N-1:0]                 o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_ovf,
  output logic                         o_unf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;      // next free slot; top lives at r_ptr-1
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_top_idx;
  logic          w_empty;
  logic          w_full;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

  // Stack update: push / pop / replace, with one-cycle overflow/underflow pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (i_en) begin
        if (i_push && (!i_pop || w_empty)) begin
          // When full, r_ptr already addresses the oldest entry.
          r_mem[r_ptr] <= i_din;
          r_ptr        <= r_ptr + PW'(1);
          if (w_full) r_ovf <= 1'b1;
          else        r_count <= r_count + CW'(1);
        end else if (i_push && i_pop) begin
          r_mem[w_top_idx] <= i_din;
        end else if (i_pop) begin
          if (w_empty) begin
            r_unf <= 1'b1;
          end else begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-PC mux, PC register and a
// return-address stack for return prediction.
// Optional macro: PC_EXCEPTION_EN (Exception/ERet inputs, EPC register).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEF_RESET_VECTOR),
  parameter logic [N-1:0] INCR         = N'(DEF_INCR),
  parameter int           RAS_DEPTH    = 8,
  parameter logic [N-1:0] EXC_VECTOR   = N'(DEF_EXC_VECTOR)
) (
  input  logic                             clk,
  input  logic                             reset,
  pc_sequencer_if.slave                    bus,
  output logic [N-1:0]                     RASTop,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   RASCount,
  output logic                             RASEmpty,
  output logic                             RASFull,
  output logic                             RASOverflow,
  output logic                             RASUnderflow
);
  logic [N-1:0] r_pc;
  logic [N-1:0] w_pc_plus;
  logic [N-1:0] w_pc_next;
  logic         w_load;
  logic         w_stk_en;
  pc_src_e      w_src;

  assign w_pc_plus   = r_pc + INCR;
  assign bus.PCValue = r_pc;
  assign bus.PCPlus  = w_pc_plus;

`ifdef PC_EXCEPTION_EN
  logic [N-1:0] r_epc;
  assign bus.EPC  = r_epc;
  // Exceptions and returns-from-exception leave the stack untouched.
  assign w_stk_en = bus.PCWrite && !bus.Exception && !bus.ERet;
`else
  assign w_stk_en = bus.PCWrite;
`endif

  // Fixed-priority next-PC source selection.
  always_comb begin
    w_src  = SRC_SEQ;
    w_load = bus.PCWrite;
    if (bus.Call)          w_src = SRC_CALL;
    else if (bus.Return)   w_src = SRC_RETURN;
    else if (bus.Redirect) w_src = SRC_REDIRECT;
`ifdef PC_EXCEPTION_EN
    if (bus.ERet) w_src = SRC_ERET;
    if (bus.Exception) begin
      w_src  = SRC_EXC;
      w_load = 1'b1;
    end
`endif
  end

  // Next-PC value for the chosen source; empty-stack returns fall back to RedirectPC.
  always_comb begin
    w_pc_next = w_pc_plus;
    case (w_src)
      SRC_REDIRECT: w_pc_next = bus.RedirectPC;
      SRC_CALL:     w_pc_next = bus.RedirectPC;
      SRC_RETURN:   w_pc_next = RASEmpty ? bus.RedirectPC : RASTop;
`ifdef PC_EXCEPTION_EN
      SRC_EXC:      w_pc_next = EXC_VECTOR;
      SRC_ERET:     w_pc_next = r_epc;
`endif
      default:      w_pc_next = w_pc_plus;
    endcase
  end

  // PC register; holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_pc <= RESET_VECTOR;
    else if (w_load) r_pc <= w_pc_next;
  end

`ifdef PC_EXCEPTION_EN
  // Capture the faulting PC on an exception, even during a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_epc <= '0;
    else if (bus.Exception) r_epc <= r_pc;
  end
`endif

  ras_stack #(
    .N     (N),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_stk_en),
    .i_push  (bus.Call),
    .i_pop   (bus.Return),
    .i_din   (w_pc_plus),
    .o_top   (RASTop),
    .o_count (RASCount),
    .o_empty (RASEmpty),
    .o_full  (RASFull),
    .o_ovf   (RASOverflow),
    .o_unf   (RASUnderflow)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
// Exercises PC_EXCEPTION_EN paths when that macro is defined.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] RASTop;
  logic [3:0]  RASCount;
  logic        RASEmpty, RASFull, RASOverflow, RASUnderflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer_if #(.N(32)) bus ();

  pc_sequencer #(
    .N            (32),
    .RESET_VECTOR (32'h0040_0000),
    .INCR         (32'd4),
    .RAS_DEPTH    (8),
    .EXC_VECTOR   (32'h8000_0180)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .RASTop       (RASTop),
    .RASCount     (RASCount),
    .RASEmpty     (RASEmpty),
    .RASFull      (RASFull),
    .RASOverflow  (RASOverflow),
    .RASUnderflow (RASUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic set_ctl(input logic pcw, input logic red, input logic cl,
                         input logic rt, input logic [31:0] rpc);
    bus.PCWrite    = pcw;
    bus.Redirect   = red;
    bus.Call       = cl;
    bus.Return     = rt;
    bus.RedirectPC = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    reset = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PC_EXCEPTION_EN
    bus.Exception = 1'b0;
    bus.ERet      = 1'b0;
`endif
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc",    bus.PCValue, 32'h0040_0000);
    chk("rst_plus",  bus.PCPlus,  32'h0040_0004);
    chk("rst_cnt",   32'(RASCount), 32'd0);
    chk("rst_empty", 32'(RASEmpty), 32'd1);
    chk("rst_top",   RASTop, 32'h0);
    chk("rst_ovf",   32'(RASOverflow), 32'd0);
    chk("rst_unf",   32'(RASUnderflow), 32'd0);
`ifdef PC_EXCEPTION_EN
    chk("rst_epc",   bus.EPC, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch
    step(); chk("seq1", bus.PCValue, 32'h0040_0004);
    step(); chk("seq2", bus.PCValue, 32'h0040_0008);
    step(); chk("seq3", bus.PCValue, 32'h0040_000C);

    // Stall with redirect pending, then release
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0100);
    step(); chk("stall1", bus.PCValue, 32'h0040_000C);
    step(); chk("stall2", bus.PCValue, 32'h0040_000C);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0100);
    step(); chk("unstall", bus.PCValue, 32'h0040_0100);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0010);
    step(); chk("redir", bus.PCValue, 32'h0040_0010);

    // Single call / return
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0200);
    step();
    chk("call_pc",  bus.PCValue, 32'h0040_0200);
    chk("call_top", RASTop, 32'h0040_0014);
    chk("call_cnt", 32'(RASCount), 32'd1);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("ret_pc",    bus.PCValue, 32'h0040_0014);
    chk("ret_empty", 32'(RASEmpty), 32'd1);

    // Nine calls into a depth-8 stack
    for (int k = 1; k <= 9; k++) begin
      set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_1000 + 32'(k) * 32'h100);
      step();
      chk("ncall_pc",  bus.PCValue, 32'h0040_1000 + 32'(k) * 32'h100);
      chk("ncall_cnt", 32'(RASCount), (k > 8) ? 32'd8 : 32'(k));
      chk("ncall_ovf", 32'(RASOverflow), (k == 9) ? 32'd1 : 32'd0);
      exp_pc = (k == 1) ? 32'h0040_0018 : 32'h0040_1004 + 32'(k - 1) * 32'h100;
      chk("ncall_top", RASTop, exp_pc);
    end
    chk("full", 32'(RASFull), 32'd1);

    // Eight returns pop calls 9 down to 2
    for (int j = 1; j <= 8; j++) begin
      set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      step();
      chk("nret_pc",  bus.PCValue, 32'h0040_1004 + 32'(9 - j) * 32'h100);
      chk("nret_cnt", 32'(RASCount), 32'(8 - j));
      if (j == 1) chk("ovf_clear", 32'(RASOverflow), 32'd0);
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0300);
    step();
    chk("unf_pc",  bus.PCValue, 32'h0040_0300);
    chk("unf",     32'(RASUnderflow), 32'd1);
    chk("unf_cnt", 32'(RASCount), 32'd0);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("unf_clear", 32'(RASUnderflow), 32'd0);
    chk("post_unf_pc", bus.PCValue, 32'h0040_0304);

    // Call+Return together on a 2-entry stack
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0400);
    step();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0500);
    step();
    chk("cr_pre_top", RASTop, 32'h0040_0404);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0600);
    step();
    chk("cr_pc",  bus.PCValue, 32'h0040_0600);
    chk("cr_cnt", 32'(RASCount), 32'd2);
    chk("cr_top", RASTop, 32'h0040_0504);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0900);
    step();
    chk("cr_ret1", bus.PCValue, 32'h0040_0504);
    chk("cr_top2", RASTop, 32'h0040_0308);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("cr_ret2", bus.PCValue, 32'h0040_0308);
    chk("cr_empty", 32'(RASEmpty), 32'd1);

    // Wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc",   bus.PCValue, 32'hFFFF_FFFC);
    chk("wrap_plus", bus.PCPlus,  32'h0);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_zero", bus.PCValue, 32'h0);

`ifdef PC_EXCEPTION_EN
    // Exception during a stall, then return from exception
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0020);
    step();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.Exception = 1'b1;
    step();
    chk("exc_pc",  bus.PCValue, 32'h8000_0180);
    chk("exc_epc", bus.EPC, 32'h0040_0020);
    bus.Exception = 1'b0;
    bus.ERet      = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("eret_pc", bus.PCValue, 32'h0040_0020);
    bus.ERet = 1'b0;
`endif

    // Asynchronous reset in mid-operation with a non-empty stack
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0700);
    step();
    chk("pre_rst_cnt", 32'(RASCount), 32'd1);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc",  bus.PCValue, 32'h0040_0000);
    chk("arst_cnt", 32'(RASCount), 32'd0);
    chk("arst_top", RASTop, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst", bus.PCValue, 32'h0040_0004);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
